// File: rtl/inst_mem_resp_if.sv
// Fetch/response and program-load bus of the instruction store.
// The master drives requests and writes; the slave returns the fetch.
interface inst_mem_resp_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  ce;
  logic [31:0]           pc;
  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [31:0]           wdata;
  logic [31:0]           inst;
  logic                  inst_valid;
  logic                  stall_req;
  logic                  addr_err;

  modport master (
    output ce, pc, we, waddr, wdata,
    input  inst, inst_valid, stall_req, addr_err
  );

  modport slave (
    input  ce, pc, we, waddr, wdata,
    output inst, inst_valid, stall_req, addr_err
  );
endinterface

// File: rtl/inst_mem_resp.sv
// Instruction store with wait-stated fetch FSM and program-load port.
// Outputs are registered; reads see pre-write data on a same-edge write.
module inst_mem_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  inst_mem_resp_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] req_addr;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           inst_q;
  logic                  valid_q;
  logic                  stall_q;
  logic                  err_q;
  logic [DEPTH_LOG2-1:0] pc_word;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  bad_req;

  assign pc_word      = bus.pc[DEPTH_LOG2+1:2];
  assign misaligned   = bus.pc[1:0] != 2'b00;
  assign out_of_range = (bus.pc >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign bad_req      = misaligned || out_of_range;

  // Program load runs in every state and through reset.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      req_addr <= '0;
      inst_q   <= 32'd0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          stall_q <= 1'b0;
          if (bus.ce) begin
            req_addr <= pc_word;
            if (bad_req) begin
              err_q  <= 1'b1;
              inst_q <= 32'd0;
            end else if (WAIT_CYCLES == 0) begin
              inst_q  <= mem[pc_word];
              valid_q <= 1'b1;
              state   <= RESP;
            end else begin
              cnt     <= WAIT_INIT;
              stall_q <= 1'b1;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus.ce) begin
            stall_q <= 1'b0;
            cnt     <= 4'd0;
            state   <= IDLE;
          end else if (cnt == 4'd0) begin
            inst_q  <= mem[req_addr];
            valid_q <= 1'b1;
            stall_q <= 1'b0;
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          stall_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          stall_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.inst       = inst_q;
  assign bus.inst_valid = valid_q;
  assign bus.stall_req  = stall_q;
  assign bus.addr_err   = err_q;
endmodule
